inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Fetch stage directly downstream of the instruction cache: owns the fetch PC, drives cache address/read-enable,
//  captures hit instructions with their PC into a small FIFO and hands them to decode with valid/ready.
//  Absorbs cache misses (holds request stable until hit) and branch/jump redirects (flush + refetch).
// PARAMETERS
//  DEPTH       4             queue entries; power of two, >= 2
//  RESET_ADDR  32'h00000000  first fetch PC after reset (word aligned)
// PORTS
//  i_clock          in   1    clock, all state on rising edge
//  i_reset          in   1    asynchronous, active-high reset
//  i_redirect       in   1    flush queue and restart fetch at i_redirect_addr
//  i_redirect_addr  in   32   InstAddr; bits [1:0] ignored (forced 0)
//  o_cache_addr     out  32   InstAddr to cache i_addr; equals fetch PC (fpc)
//  o_cache_re       out  1    cache read enable
//  i_cache_inst     in   32   Inst from cache, valid when i_cache_hit=1
//  i_cache_busy     in   1    cache refilling (informational; miss = re & !hit)
//  i_cache_hit      in   1    instruction available this cycle
//  o_valid          out  1    queue head valid to decode
//  o_inst           out  32   Inst at queue head
//  o_pc             out  32   InstAddr of queue head
//  i_ready          in   1    decode accepts head; pop when o_valid & i_ready
// BEHAVIOUR
//  Reset: fpc=RESET_ADDR, count=0, state=RUN, o_valid=0, o_cache_re=0 while i_reset high; outputs from regs.
//  States (FetchState): RUN, MISS, DRAIN.
//   RUN:   o_cache_re = space & !i_redirect, space = (count<DEPTH) | (o_valid & i_ready).
//          re&hit -> push {fpc,i_cache_inst}, fpc<=fpc+4, stay RUN. re&!hit -> MISS.
//   MISS:  o_cache_re=1, addr held = fpc (never changes during miss). hit -> push, fpc+=4, RUN.
//          Space for the push is guaranteed: MISS only entered with space and pops only free space.
//   DRAIN: redirect arrived during MISS. re=1 on old fpc until hit; hit data discarded (no push);
//          then fpc<=pend_addr, RUN. Further redirects in DRAIN overwrite pend_addr.
//  Redirect (priority over push/pop): in RUN -> queue cleared (count=0, o_valid=0 next cycle),
//   fpc<=redirect addr, any same-cycle hit discarded, same-cycle pop ignored; first fetch of new
//   target next cycle. In MISS -> pend_addr<=addr, queue cleared, state DRAIN.
//  Latency: hit in cycle N -> o_valid/o_inst/o_pc at cycle N+1. One instruction per cycle sustained.
//  Queue: full (count==DEPTH) with simultaneous pop+push allowed; empty push+pop not bypassed (o_valid
//   only from stored entries). Read/write pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
//  Arithmetic: fpc+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 32'h00000000, no flag.
//  o_inst/o_pc hold last head value when o_valid=0 (don't-care for checks).
//  Reset mid-miss: state forced RUN immediately; cache refill outcome ignored.
// CONFIGURATION
//  FETCH_PERF_COUNTERS_EN defined: extra ports o_perf_fetched (32, out, count of pushed instructions)
//   and o_perf_stall (32, out, cycles with o_cache_re & !i_cache_hit); both reset to 0, wrap modulo 2^32,
//   DRAIN cycles count as stall, discarded hits do not count as fetched.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Types package: FetchEntry struct {InstAddr pc; Inst inst;}, FetchState enum {RUN, MISS, DRAIN},
//   constant INST_BYTES = 4.
//  Sub-module inst_queue_fifo (#(DEPTH), FetchEntry data, push/pop/flush, full/empty/count); the FSM,
//   fpc, pend_addr and perf counters stay in inst_fetch_queue.
// TESTING
//  1 Reset RESET_ADDR=0x100, cache always hits, i_ready=1 -> addrs 0x100,0x104,0x108..., o_valid from cycle 2, one/cycle.
//  2 Miss at 0x104 held 5 cycles -> o_cache_addr stays 0x104 and re=1 all 5 cycles; 0x104 entry follows hit by 1 cycle.
//  3 i_ready=0, DEPTH=4 -> exactly 4 pushes (0x0..0xC), then re=0; one pop + hit same cycle keeps count=4.
//  4 Redirect to 0x2002 in RUN with 3 queued -> o_valid=0 next cycle, next fetch addr 0x2000, old entries gone.
//  5 Redirect to 0x400 during miss on 0x80 -> re held on 0x80 until hit, 0x80 not delivered, next fetch 0x400.
//  6 fpc=0xFFFFFFFC hit -> next addr 0x0; with FETCH_PERF_COUNTERS_EN, 3 miss cycles + 1 hit -> stall=3, fetched=1.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the fetch stage: addresses, instructions, queue entries and fetch FSM states.
package inst_fetch_queue_pkg;

  localparam int INST_BYTES = 4;

  typedef logic [31:0] InstAddr;
  typedef logic [31:0] Inst;

  typedef struct packed {
    InstAddr pc;
    Inst     inst;
  } FetchEntry;

  typedef enum logic [1:0] {
    RUN,
    MISS,
    DRAIN
  } FetchState;

  function automatic InstAddr word_align(input InstAddr addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Cache-side and decode-side signals of the fetch stage; master is the fetch unit, slave its environment.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic    redirect;
  InstAddr redirect_addr;
  InstAddr cache_addr;
  logic    cache_re;
  Inst     cache_inst;
  logic    cache_busy;
  logic    cache_hit;
  logic    valid;
  Inst     inst;
  InstAddr pc;
  logic    ready;

  modport master (
    input  redirect, redirect_addr, cache_inst, cache_busy, cache_hit, ready,
    output cache_addr, cache_re, valid, inst, pc
  );

  modport slave (
    output redirect, redirect_addr, cache_inst, cache_busy, cache_hit, ready,
    input  cache_addr, cache_re, valid, inst, pc
  );
endinterface

// File: rtl/inst_queue_fifo.sv
// Small FIFO of fetched {pc, inst} entries; flush wins over push/pop, head read straight from storage.
module inst_queue_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         push,
  input  FetchEntry                    push_data,
  input  logic                         pop,
  input  logic                         flush,
  output FetchEntry                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  FetchEntry        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty && !flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge i_clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, rides out cache misses and redirects, queues hits for decode.
// Optional FETCH_PERF_COUNTERS_EN adds fetched-instruction and stall-cycle counters.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int            DEPTH      = 4,
  parameter logic [31:0]   RESET_ADDR = 32'h0000_0000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  inst_fetch_queue_if.master   bus
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]          o_perf_fetched,
  output logic [31:0]          o_perf_stall
`endif
);
  FetchState state_reg;
  InstAddr   fpc_reg;
  InstAddr   pend_addr_reg;
  FetchEntry head;
  logic      full;
  logic      empty;
  logic      pop;
  logic      push;
  logic      space;
  logic      cache_re;
  logic [$clog2(DEPTH+1)-1:0] unused_count;
  logic      unused_busy;

  // Miss detection relies on re & !hit alone; the busy line carries no extra information.
  assign unused_busy = bus.cache_busy;

  assign bus.valid      = !empty;
  assign bus.inst       = head.inst;
  assign bus.pc         = head.pc;
  assign bus.cache_addr = fpc_reg;
  assign bus.cache_re   = cache_re;

  assign pop   = bus.valid && bus.ready;
  assign space = !full || pop;
  assign push  = cache_re && bus.cache_hit && !bus.redirect && (state_reg != DRAIN);

  always_comb begin
    cache_re = 1'b0;
    if (!i_reset) begin
      case (state_reg)
        RUN:     cache_re = space && !bus.redirect;
        default: cache_re = 1'b1;
      endcase
    end
  end

  inst_queue_fifo #(.DEPTH(DEPTH)) u_queue (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .push      (push),
    .push_data ('{pc: fpc_reg, inst: bus.cache_inst}),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (unused_count)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= RUN;
      fpc_reg       <= RESET_ADDR;
      pend_addr_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (bus.redirect) begin
            fpc_reg <= word_align(bus.redirect_addr);
          end else if (cache_re) begin
            if (bus.cache_hit) fpc_reg <= fpc_reg + 32'(INST_BYTES);
            else               state_reg <= MISS;
          end
        end
        MISS: begin
          if (bus.redirect) begin
            pend_addr_reg <= word_align(bus.redirect_addr);
            state_reg     <= DRAIN;
          end else if (bus.cache_hit) begin
            fpc_reg   <= fpc_reg + 32'(INST_BYTES);
            state_reg <= RUN;
          end
        end
        DRAIN: begin
          // The outstanding request must complete before the new target can be issued.
          if (bus.redirect) pend_addr_reg <= word_align(bus.redirect_addr);
          if (bus.cache_hit) begin
            fpc_reg   <= bus.redirect ? word_align(bus.redirect_addr) : pend_addr_reg;
            state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
    end else begin
      if (push)                         perf_fetched_reg <= perf_fetched_reg + 32'd1;
      if (cache_re && !bus.cache_hit)   perf_stall_reg   <= perf_stall_reg + 32'd1;
    end
  end

  assign o_perf_fetched = perf_fetched_reg;
  assign o_perf_stall   = perf_stall_reg;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-based behavioural model of the fetch stage.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  inst_fetch_queue_if bus ();
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .o_perf_fetched (perf_fetched),
    .o_perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Behavioural model: queue contents, fetch PC, outstanding miss and pending redirect.
  FetchEntry   mq[$];
  logic [31:0] m_fpc;
  bit          m_waiting;
  bit          m_pend_valid;
  logic [31:0] m_pend;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fpc        = RESET_ADDR;
    m_waiting    = 0;
    m_pend_valid = 0;
    m_pend       = '0;
    m_fetched    = '0;
    m_stall      = '0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model, return at posedge+1.
  task automatic cycle(input logic r, input logic redir, input logic [31:0] raddr,
                       input logic hit, input logic rdy);
    bit          exp_re;
    bit          space;
    logic [31:0] aligned;
    rst               = r;
    bus.redirect      = redir;
    bus.redirect_addr = raddr;
    bus.cache_hit     = hit;
    bus.cache_inst    = inst_of(m_fpc);
    bus.cache_busy    = m_waiting && !hit;
    bus.ready         = rdy;
    if (r) model_reset();
    @(negedge clk);
    aligned = {raddr[31:2], 2'b00};
    space   = (mq.size() < DEPTH) || (mq.size() > 0 && rdy);
    exp_re  = r ? 1'b0 : (m_waiting ? 1'b1 : (space && !redir));
    check("cache_re", 32'(bus.cache_re), 32'(exp_re));
    if (exp_re || r) check("cache_addr", bus.cache_addr, m_fpc);
    check("valid", 32'(bus.valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("head_pc", bus.pc, mq[0].pc);
      check("head_inst", bus.inst, mq[0].inst);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall", perf_stall, m_stall);
`endif
    if (!r) begin
      if (exp_re && !hit) m_stall++;
      if (!redir && rdy && mq.size() > 0) begin
        $display("pop pc=%08h inst=%08h", mq[0].pc, mq[0].inst);
        void'(mq.pop_front());
      end
      if (!m_waiting) begin
        if (redir) begin
          mq.delete();
          m_fpc = aligned;
        end else if (exp_re) begin
          if (hit) begin
            mq.push_back('{pc: m_fpc, inst: inst_of(m_fpc)});
            m_fetched++;
            m_fpc += 4;
          end else begin
            m_waiting = 1;
          end
        end
      end else if (!m_pend_valid) begin
        if (redir) begin
          mq.delete();
          m_pend_valid = 1;
          m_pend       = aligned;
        end else if (hit) begin
          mq.push_back('{pc: m_fpc, inst: inst_of(m_fpc)});
          m_fetched++;
          m_fpc += 4;
          m_waiting = 0;
        end
      end else begin
        if (redir) m_pend = aligned;
        if (hit) begin
          m_fpc        = m_pend;
          m_waiting    = 0;
          m_pend_valid = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    // Reset held: re low, address at RESET_ADDR, nothing valid.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1);

    // Streaming with every access hitting.
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1);
    check("stream_addr", bus.cache_addr, 32'h118);

    // Miss on the next address held for five cycles.
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
    check("miss_addr_held", bus.cache_addr, 32'h104);
    cycle(0, 0, 0, 1, 1);
    check("miss_delivered_pc", bus.pc, 32'h104);

    // Back-pressure: exactly DEPTH pushes from 0x0, then pop+push while full.
    cycle(0, 1, 32'h0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
    check("full_fpc", bus.cache_addr, 32'h10);
    cycle(0, 0, 0, 1, 1);
    check("full_refill_fpc", bus.cache_addr, 32'h14);

    // Redirect in RUN with three queued entries.
    cycle(0, 1, 32'h1000, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 32'h2002, 1, 0);
    check("redir_valid", 32'(bus.valid), 32'h0);
    check("redir_addr", bus.cache_addr, 32'h2000);
    cycle(0, 0, 0, 1, 1);

    // Redirect during a miss: old request drains, its data is dropped.
    cycle(0, 1, 32'h80, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 32'h400, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("drain_addr", bus.cache_addr, 32'h80);
    cycle(0, 0, 0, 1, 1);
    check("drain_next", bus.cache_addr, 32'h400);
    check("drain_valid", 32'(bus.valid), 32'h0);

    // Wrap at the top of the address space with counted stalls.
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 32'hFFFF_FFFF, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    check("wrap_addr", bus.cache_addr, 32'h0);
    check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_COUNTERS_EN
    check("wrap_stall", perf_stall, 32'd3);
    check("wrap_fetched", perf_fetched, 32'd1);
`endif

    // Reset in the middle of a miss.
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 19) == 0),
            $urandom,
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
